muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the pipelined MIPS core, sitting beside the ALU in the execute stage. It consumes a 3-bit multiply/divide operation code produced by the control decoder from the R-type `funct` field. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one cycle, and holds the architectural HI/LO registers. `busy` is the stall source for the hazard unit.

---
 rtl/muldiv_unit_if.sv | 28 ++
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Multiply/divide request and result bundle between the execute stage and the MDU.
// Latency: none (wires only).
// Backpressure: the requester must hold off while busy is high; start is ignored then.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       mdop;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Execute-stage side: issues operations, observes HI/LO and the stall source.
    modport master (
        output start, mdop, a, b, cancel,
        input  busy, done, hi, lo
    );

    // MDU side.
    modport slave (
        input  start, mdop, a, b, cancel,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding HI/LO; MDU_DIV_EN compiles in DIV/DIVU.
// Latency: MULT/MULTU/DIV/DIVU WIDTH+1 cycles to result; MTHI/MTLO update at the sampling edge.
// Backpressure: busy stalls the pipeline; start is ignored while busy, cancel aborts with no result.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  mdu
);
    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
`endif

    typedef enum logic [1:0] {
        IDLE,
        MUL
`ifdef MDU_DIV_EN
        , DIV
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // MUL: {partial product, remaining multiplier bits}; DIV: {partial remainder, dividend/quotient bits}
    logic [2*WIDTH-1:0] acc_q, acc_d;
    // Multiplicand magnitude in MUL, divisor magnitude in DIV
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               neg_q, neg_d;      // product / quotient must be negated
    logic               done_q, done_d;
`ifdef MDU_DIV_EN
    logic               rneg_q, rneg_d;    // remainder takes the dividend's sign
`endif

    // Operand conditioning: signed ops work on magnitudes, sign fixed up at the end.
    // Magnitude of the most-negative value is 2^(WIDTH-1), which fits unsigned.
    logic             op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign op_signed = ~mdu.mdop[0];
    assign a_neg     = op_signed & mdu.a[WIDTH-1];
    assign b_neg     = op_signed & mdu.b[WIDTH-1];
    assign a_mag     = a_neg ? -mdu.a : mdu.a;
    assign b_mag     = b_neg ? -mdu.b : mdu.b;

    // Shift-add step: add multiplicand into the upper half if the multiplier LSB is set, shift right.
    logic [WIDTH-1:0]   mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next, mul_res;
    assign mul_add  = acc_q[0] ? opnd_q : '0;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};
    assign mul_res  = neg_q ? -mul_next : mul_next;

`ifdef MDU_DIV_EN
    // Restoring step: shift the next dividend bit into the remainder, trial-subtract the divisor.
    // A zero divisor never borrows, which naturally yields all-ones quotient and |a| remainder.
    logic [WIDTH:0]     div_r, div_diff;
    logic [2*WIDTH-1:0] div_next;
    logic [WIDTH-1:0]   quo_res, rem_res;
    assign div_r    = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff = div_r - {1'b0, opnd_q};
    assign div_next = div_diff[WIDTH] ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign quo_res  = neg_q  ? -div_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
    assign rem_res  = rneg_q ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
`endif

    // Next-state and datapath control; cancel beats start and beats the final iteration.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        neg_d   = neg_q;
        done_d  = 1'b0;
`ifdef MDU_DIV_EN
        rneg_d  = rneg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mdu.start && !mdu.cancel) begin
                    case (mdu.mdop)
                        OP_MULT, OP_MULTU: begin
                            acc_d   = {{WIDTH{1'b0}}, b_mag};
                            opnd_d  = a_mag;
                            neg_d   = a_neg ^ b_neg;
                            cnt_d   = '0;
                            state_d = MUL;
                        end
`ifdef MDU_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            acc_d   = {{WIDTH{1'b0}}, a_mag};
                            opnd_d  = b_mag;
                            // Divide by zero: leave quotient all ones; remainder sign restores a.
                            neg_d   = (mdu.b != '0) & (a_neg ^ b_neg);
                            rneg_d  = a_neg;
                            cnt_d   = '0;
                            state_d = DIV;
                        end
`endif
                        OP_MTHI: begin
                            hi_d   = mdu.a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = mdu.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (mdu.cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = mul_res[2*WIDTH-1:WIDTH];
                        lo_d    = mul_res[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`ifdef MDU_DIV_EN
            DIV: begin
                if (mdu.cancel) begin
                    state_d = IDLE;
                end else begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        hi_d    = rem_res;
                        lo_d    = quo_res;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, working and architectural registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            neg_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef MDU_DIV_EN
            rneg_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            neg_q   <= neg_d;
            done_q  <= done_d;
`ifdef MDU_DIV_EN
            rneg_q  <= rneg_d;
`endif
        end
    end

    assign mdu.busy = (state_q != IDLE);
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized traffic against an arithmetic model.
// Latency: model predicts WIDTH+1 cycle results and one-cycle MTHI/MTLO.
// Backpressure: random starts during busy, cancels and back-to-back ops are all exercised.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 0;

    muldiv_unit_if #(.WIDTH(W)) mdu_if ();

    muldiv_unit #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .mdu   (mdu_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result {hi, lo} of an iterative op, from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] qv, rv, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin
                q = sa * sb;
                p = q;
                return p;
            end
            3'd1: begin
                p = {32'h0, a} * {32'h0, b};
                return p;
            end
            3'd2: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                q  = sa / sb;
                r  = sa % sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            3'd3: begin
                if (b == 32'h0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Behavioural model: countdown of remaining cycles for an in-flight op.
    int          m_left = 0;
    logic [63:0] m_pend = '0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    bit          m_done = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_left = 0;
            m_hi   = '0;
            m_lo   = '0;
            m_done = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                if (mdu_if.cancel) begin
                    m_left = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_hi   = m_pend[63:32];
                        m_lo   = m_pend[31:0];
                        m_done = 1;
                    end
                end
            end else if (mdu_if.start && !mdu_if.cancel) begin
                case (mdu_if.mdop)
                    3'd0, 3'd1: begin
                        m_pend = ref_result(mdu_if.mdop, mdu_if.a, mdu_if.b);
                        m_left = W;
                    end
`ifdef MDU_DIV_EN
                    3'd2, 3'd3: begin
                        m_pend = ref_result(mdu_if.mdop, mdu_if.a, mdu_if.b);
                        m_left = W;
                    end
`endif
                    3'd4: begin
                        m_hi   = mdu_if.a;
                        m_done = 1;
                    end
                    3'd5: begin
                        m_lo   = mdu_if.a;
                        m_done = 1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Cycle-by-cycle compare of every output against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_busy", {63'h0, mdu_if.busy}, {63'h0, (m_left > 0)});
            check("cyc_done", {63'h0, mdu_if.done}, {63'h0, m_done});
            check("cyc_hi", {32'h0, mdu_if.hi}, {32'h0, m_hi});
            check("cyc_lo", {32'h0, mdu_if.lo}, {32'h0, m_lo});
        end
    end

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdu_if.start = 1'b1;
        mdu_if.mdop  = op;
        mdu_if.a     = a;
        mdu_if.b     = b;
        @(negedge clk);
        mdu_if.start = 1'b0;
    endtask

    // Counts busy cycles until done is seen; bounded so a stuck DUT cannot hang the run.
    task automatic wait_done(input string name, output int nbusy);
        bit seen;
        nbusy = 0;
        seen  = 0;
        for (int i = 0; i < 64 && !seen; i++) begin
            if (mdu_if.done) seen = 1;
            else begin
                if (mdu_if.busy) nbusy++;
                @(negedge clk);
            end
        end
        check({name, "_done_seen"}, {63'h0, seen}, 64'h1);
    endtask

    // Watches a window and returns how many busy and done cycles occurred.
    task automatic watch(input int cycles, output int nbusy, output int ndone);
        nbusy = 0;
        ndone = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (mdu_if.busy) nbusy++;
            if (mdu_if.done) ndone++;
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nb, nd;
        mdu_if.start  = 1'b0;
        mdu_if.mdop   = 3'd0;
        mdu_if.a      = '0;
        mdu_if.b      = '0;
        mdu_if.cancel = 1'b0;
        reset = 1'b1;

        // Pin the model against hand-computed results.
        check("model_mult", ref_result(3'd0, 32'hFFFF_FFFD, 32'd7), 64'hFFFF_FFFF_FFFF_FFEB);
        check("model_multu", ref_result(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("model_div", ref_result(3'd2, -32'd7, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        check("model_divu0", ref_result(3'd3, 32'd100, 32'd0), 64'h0000_0064_FFFF_FFFF);
        check("model_divovf", ref_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);

        #3 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'h0, mdu_if.hi}, 64'h0);
        check("rst_lo", {32'h0, mdu_if.lo}, 64'h0);
        check("rst_busy", {63'h0, mdu_if.busy}, 64'h0);
        check("rst_done", {63'h0, mdu_if.done}, 64'h0);
        cmp_en = 1;
        #2 reset = 1'b1;

        // MULT -3 x 7
        issue(3'd0, 32'hFFFF_FFFD, 32'd7);
        wait_done("mult", nb);
        check("mult_busy_cycles", 64'(nb), 64'd32);
        check("mult_hi", {32'h0, mdu_if.hi}, 64'hFFFF_FFFF);
        check("mult_lo", {32'h0, mdu_if.lo}, 64'hFFFF_FFEB);

        // MULTU max x max
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("multu", nb);
        check("multu_hi", {32'h0, mdu_if.hi}, 64'hFFFF_FFFE);
        check("multu_lo", {32'h0, mdu_if.lo}, 64'h0000_0001);

        // MTLO then MTHI on consecutive cycles
        @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.mdop = 3'd5; mdu_if.a = 32'h1234;
        @(negedge clk);
        check("mtlo_done", {63'h0, mdu_if.done}, 64'h1);
        check("mtlo_lo", {32'h0, mdu_if.lo}, 64'h1234);
        mdu_if.mdop = 3'd4; mdu_if.a = 32'h5678;
        @(negedge clk);
        mdu_if.start = 1'b0;
        check("mthi_done", {63'h0, mdu_if.done}, 64'h1);
        check("mthi_hi", {32'h0, mdu_if.hi}, 64'h5678);
        check("mthi_busy", {63'h0, mdu_if.busy}, 64'h0);

        // Cancel a MULT at cycle 10
        issue(3'd1, 32'd12345, 32'd678);
        repeat (9) @(negedge clk);
        mdu_if.cancel = 1'b1;
        @(negedge clk);
        mdu_if.cancel = 1'b0;
        check("cancel_mul_busy", {63'h0, mdu_if.busy}, 64'h0);
        watch(40, nb, nd);
        check("cancel_mul_no_done", 64'(nd), 64'd0);
        check("cancel_mul_hi", {32'h0, mdu_if.hi}, 64'h5678);
        check("cancel_mul_lo", {32'h0, mdu_if.lo}, 64'h1234);

`ifdef MDU_DIV_EN
        issue(3'd2, -32'd7, 32'd2);
        wait_done("div", nb);
        check("div_busy_cycles", 64'(nb), 64'd32);
        check("div_lo", {32'h0, mdu_if.lo}, 64'hFFFF_FFFD);
        check("div_hi", {32'h0, mdu_if.hi}, 64'hFFFF_FFFF);
        issue(3'd3, 32'd100, 32'd0);
        wait_done("divu0", nb);
        check("divu0_lo", {32'h0, mdu_if.lo}, 64'hFFFF_FFFF);
        check("divu0_hi", {32'h0, mdu_if.hi}, 64'd100);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf", nb);
        check("divovf_lo", {32'h0, mdu_if.lo}, 64'h8000_0000);
        check("divovf_hi", {32'h0, mdu_if.hi}, 64'h0);
        issue(3'd3, 32'd99999, 32'd7);
        repeat (9) @(negedge clk);
        mdu_if.cancel = 1'b1;
        @(negedge clk);
        mdu_if.cancel = 1'b0;
        check("cancel_div_busy", {63'h0, mdu_if.busy}, 64'h0);
        watch(40, nb, nd);
        check("cancel_div_no_done", 64'(nd), 64'd0);
        check("cancel_div_lo", {32'h0, mdu_if.lo}, 64'h8000_0000);
        check("cancel_div_hi", {32'h0, mdu_if.hi}, 64'h0);
`else
        issue(3'd2, -32'd7, 32'd2);
        watch(40, nb, nd);
        check("nodiv_busy", 64'(nb), 64'd0);
        check("nodiv_done", 64'(nd), 64'd0);
        issue(3'd0, 32'd6, 32'd7);
        wait_done("nodiv_mult", nb);
        check("nodiv_mult_lo", {32'h0, mdu_if.lo}, 64'd42);
        check("nodiv_mult_hi", {32'h0, mdu_if.hi}, 64'd0);
`endif

        // Start issued mid-MULT is ignored
        issue(3'd1, 32'd9, 32'd11);
        repeat (4) @(negedge clk);
        mdu_if.start = 1'b1; mdu_if.mdop = 3'd1; mdu_if.a = 32'hFFFF_FFFF; mdu_if.b = 32'hFFFF_FFFF;
        @(negedge clk);
        mdu_if.start = 1'b0;
        wait_done("midstart", nb);
        check("midstart_lo", {32'h0, mdu_if.lo}, 64'd99);
        check("midstart_hi", {32'h0, mdu_if.hi}, 64'd0);
        watch(5, nb, nd);
        check("midstart_no_second", 64'(nb), 64'd0);

        // Reset asserted at cycle 5 of a MULT
        issue(3'd0, 32'd5, 32'd9);
        repeat (4) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("midrst_busy", {63'h0, mdu_if.busy}, 64'h0);
        check("midrst_done", {63'h0, mdu_if.done}, 64'h0);
        check("midrst_hi", {32'h0, mdu_if.hi}, 64'h0);
        check("midrst_lo", {32'h0, mdu_if.lo}, 64'h0);
        @(negedge clk);
        #2 reset = 1'b1;
        watch(40, nb, nd);
        check("midrst_no_done", 64'(nd), 64'd0);

        // Randomized traffic: starts at any time, occasional cancels, all opcodes.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            mdu_if.start  = ($urandom_range(0, 3) == 0);
            mdu_if.mdop   = 3'($urandom_range(0, 7));
            mdu_if.a      = rnd_opnd();
            mdu_if.b      = rnd_opnd();
            mdu_if.cancel = ($urandom_range(0, 99) == 0);
        end
        @(negedge clk);
        mdu_if.start  = 1'b0;
        mdu_if.cancel = 1'b0;
        repeat (40) @(negedge clk);
        cmp_en = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
